// File: rtl/rv_exception_unit.sv
// Trap and interrupt sequencer for the execute stage: prioritises exceptions and
// interrupts, redirects fetch to the handler and back, and owns the machine timer.
module rv_exception_unit #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0008
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_stall_i,
    input  logic        x_valid_i,
    input  logic        x_illegal_i,
    input  logic        x_misaligned_i,
    input  logic        x_ebreak_i,
    input  logic        x_ecall_i,
    input  logic        x_mret_i,
    input  logic        csr_mstatus_mie_i,
    input  logic [1:0]  csr_irq_mask_i,
    input  logic [31:0] csr_mepc_i,
    input  logic        timecmp_we_i,
    input  logic [31:0] timecmp_i,
    input  logic        irq_i,
    output logic        x_kill_o,
    output logic        x_exception_o,
    output logic        x_exception_irq_o,
    output logic [2:0]  x_exception_id_o,
    output logic        f_load_o,
    output logic [31:0] f_pc_o,
    output logic        ext_pending_o,
    output logic        timer_pending_o,
    output logic        in_handler_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    state_t      state_reg, state_next;
    logic        irq_meta_reg, irq_sync_reg;
    logic [31:0] mtime_reg, mtimecmp_reg;
    logic        timer_pending_reg;
    logic        exception_reg, exception_irq_reg, f_load_reg;
    logic [2:0]  exception_id_reg;
    logic [31:0] f_pc_reg;

    logic        in_handler, accept, ext_eligible, timer_eligible;
    logic        trap_sel, trap_irq, mret_sel;
    logic [2:0]  trap_id;

    // Synchronizer, timer and compare register keep running in every state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_meta_reg      <= 1'b0;
            irq_sync_reg      <= 1'b0;
            mtime_reg         <= 32'd0;
            mtimecmp_reg      <= 32'hFFFF_FFFF;
            timer_pending_reg <= 1'b0;
        end else begin
            irq_meta_reg <= irq_i;
            irq_sync_reg <= irq_meta_reg;
            mtime_reg    <= mtime_reg + 32'd1;
            if (timecmp_we_i) begin
                mtimecmp_reg      <= timecmp_i;
                timer_pending_reg <= 1'b0;
            end else if (mtime_reg == mtimecmp_reg) begin
                timer_pending_reg <= 1'b1;
            end
        end
    end

    assign in_handler     = (state_reg == ST_HANDLER);
    assign accept         = x_valid_i && !x_stall_i &&
                            (state_reg == ST_IDLE || state_reg == ST_HANDLER);
    assign ext_eligible   = csr_mstatus_mie_i && csr_irq_mask_i[0] && irq_sync_reg && !in_handler;
    assign timer_eligible = csr_mstatus_mie_i && csr_irq_mask_i[1] && timer_pending_reg && !in_handler;

    // Priority chain; an mret outside the handler is reported as illegal.
    always_comb begin
        trap_sel = 1'b0;
        trap_irq = 1'b0;
        trap_id  = 3'd0;
        mret_sel = 1'b0;
        if (accept) begin
            if (ext_eligible) begin
                trap_sel = 1'b1;
                trap_irq = 1'b1;
                trap_id  = 3'd3;
            end else if (timer_eligible) begin
                trap_sel = 1'b1;
                trap_irq = 1'b1;
                trap_id  = 3'd7;
            end else if (x_illegal_i || (x_mret_i && !in_handler)) begin
                trap_sel = 1'b1;
                trap_id  = 3'd0;
            end else if (x_misaligned_i) begin
                trap_sel = 1'b1;
                trap_id  = 3'd1;
            end else if (x_ebreak_i) begin
                trap_sel = 1'b1;
                trap_id  = 3'd2;
            end else if (x_ecall_i) begin
                trap_sel = 1'b1;
                trap_id  = 3'd4;
            end else if (x_mret_i) begin
                mret_sel = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (trap_sel) state_next = ST_TRAP;
            ST_TRAP:    state_next = ST_HANDLER;
            ST_HANDLER: begin
                if (trap_sel)      state_next = ST_TRAP;
                else if (mret_sel) state_next = ST_RETURN;
            end
            ST_RETURN:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg         <= ST_IDLE;
            exception_reg     <= 1'b0;
            exception_irq_reg <= 1'b0;
            exception_id_reg  <= 3'd0;
            f_load_reg        <= 1'b0;
            f_pc_reg          <= 32'd0;
        end else begin
            state_reg         <= state_next;
            exception_reg     <= trap_sel;
            exception_irq_reg <= trap_sel && trap_irq;
            exception_id_reg  <= trap_sel ? trap_id : 3'd0;
            f_load_reg        <= trap_sel || mret_sel;
            f_pc_reg          <= trap_sel ? TRAP_VECTOR : (mret_sel ? csr_mepc_i : 32'd0);
        end
    end

    // Redirect states swallow whatever sits in execute.
    assign x_kill_o          = (accept && (trap_sel || mret_sel)) ||
                               ((state_reg == ST_TRAP || state_reg == ST_RETURN) && x_valid_i);
    assign x_exception_o     = exception_reg;
    assign x_exception_irq_o = exception_irq_reg;
    assign x_exception_id_o  = exception_id_reg;
    assign f_load_o          = f_load_reg;
    assign f_pc_o            = f_pc_reg;
    assign ext_pending_o     = irq_sync_reg;
    assign timer_pending_o   = timer_pending_reg;
    assign in_handler_o      = in_handler;

endmodule

// File: doc/rv_exception_unit.md
RV_EXCEPTION_UNIT -- requirements
Module: rv_exception_unit

Interface
REQ-001 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0008, the handler entry address.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk_i  in  1  clock; all state changes on the rising edge.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 x_stall_i  in  1  execute stage stalled; the instruction is not accepted this cycle.
REQ-006 x_valid_i  in  1  a valid instruction is in the execute stage.
REQ-007 x_illegal_i, x_misaligned_i, x_ebreak_i, x_ecall_i, x_mret_i  in  1 each  decoded trap and return flags of that instruction.
REQ-008 csr_mstatus_mie_i  in  1  global interrupt enable from the CSR unit.
REQ-009 csr_irq_mask_i  in  2  per-source enable; bit0 is external, bit1 is timer.
REQ-010 csr_mepc_i  in  32  return address held by the CSR unit.
REQ-011 timecmp_we_i / timecmp_i  in  1 / 32  write strobe and value for the timer compare register.
REQ-012 irq_i  in  1  asynchronous, level-sensitive external interrupt.
REQ-013 x_kill_o  out  1  combinational; suppresses write-back of the current instruction.
REQ-014 x_exception_o, x_exception_irq_o  out  1 each  registered one-cycle trap pulse to the CSR unit, and its interrupt flag.
REQ-015 x_exception_id_o  out  3  registered cause code.
REQ-016 f_load_o / f_pc_o  out  1 / 32  registered fetch redirect strobe and target.
REQ-017 ext_pending_o, timer_pending_o  out  1 each  synchronized pending bits, for the mip CSR.
REQ-018 in_handler_o  out  1  the state is HANDLER.

Function
REQ-019 irq_i SHALL pass through a 2-flop synchronizer, so ext_pending_o is irq_i delayed by 2 cycles.
REQ-020 mtime SHALL be a 32-bit counter that increments every cycle and wraps from FFFF_FFFF to 0.
REQ-021 The timer pending bit SHALL set on the cycle mtime==mtimecmp and SHALL stay sticky until timecmp_we_i.
REQ-022 When timecmp_we_i and a compare match occur in the same cycle, the write SHALL win: pending clears and mtimecmp loads timecmp_i.
REQ-023 An instruction is accepted when x_valid_i=1 and x_stall_i=0; no decision is taken and no state changes on an unaccepted cycle.
REQ-024 An interrupt SHALL be eligible when csr_mstatus_mie_i=1, its mask bit is 1, its pending bit is 1, and the state is not HANDLER.
REQ-025 Trap priority on an accepted cycle SHALL be: external irq (irq=1, id 3), timer irq (irq=1, id 7), illegal (id 0), misaligned (id 1), ebreak (id 2), ecall (id 4).
REQ-026 x_mret_i SHALL have the lowest priority and is honoured only in state HANDLER; an mret outside HANDLER is treated as illegal (id 0).
REQ-027 x_kill_o SHALL be 1 in the same cycle when a trap or an mret is selected; an interrupt kills the instruction it preempts.
REQ-028 On a selected trap, the cycle after SHALL give x_exception_o=1 with x_exception_irq_o and x_exception_id_o, f_load_o=1 and f_pc_o=TRAP_VECTOR, each for exactly 1 cycle.
REQ-029 On a selected mret, the cycle after SHALL give f_load_o=1 with f_pc_o=csr_mepc_i sampled on the mret cycle; x_exception_o stays 0.
REQ-030 The state machine SHALL have states IDLE, TRAP, HANDLER and RETURN.
REQ-031 IDLE goes to TRAP on a trap; TRAP goes to HANDLER unconditionally after 1 cycle.
REQ-032 HANDLER goes to TRAP on a synchronous trap (nesting is allowed; interrupts are blocked), and to RETURN on mret.
REQ-033 RETURN goes to IDLE unconditionally after 1 cycle.
REQ-034 In TRAP and RETURN no instruction SHALL be accepted, and x_kill_o=1 if x_valid_i is asserted.
REQ-035 Pending bits SHALL keep updating in every state; an interrupt pending during HANDLER is taken on the first accepted cycle in IDLE.

Reset
REQ-036 On rst_i assertion, all outputs SHALL go to 0 asynchronously, and the state SHALL be IDLE.
REQ-037 Reset SHALL clear mtime to 0, set mtimecmp to FFFF_FFFF, and clear both synchronizer flops and the timer pending bit.
REQ-038 Reset asserted during TRAP or RETURN SHALL abort the redirect, with no f_load_o pulse after release.

Verification
REQ-039 Accepted x_ecall_i at PC 0x100 -> same cycle x_kill_o=1; next cycle x_exception_o=1, irq=0, id=4, f_pc_o=0x8; then in_handler_o=1.
REQ-040 In HANDLER, x_mret_i with csr_mepc_i=0x100 -> next cycle f_load_o=1, f_pc_o=0x100; state RETURN, then IDLE.
REQ-041 irq_i rises with mie=1 and mask=01 -> ext_pending_o=1 after 2 cycles; next accepted instruction is killed; exception irq=1, id=3.
REQ-042 timecmp_i=20 written at mtime=10 -> timer_pending_o=1 at mtime=20; it stays 1 until the next write; with mask=10 the trap is taken with id=7.
REQ-043 x_illegal_i and x_ecall_i with an external irq pending in the same cycle -> id=3; with the irq masked -> id=0.
REQ-044 x_ecall_i held with x_stall_i=1 for 3 cycles -> no kill or pulse during the stall; the trap is taken on the first unstalled cycle.
